// File: rtl/ts_null_packet_inserter_if.sv
// Byte-stream and status bundle around the TS null packet inserter.
// valid_in qualifies sync_in/data_in for exactly one clk and there is no ready: input the buffer cannot hold is dropped;
// valid_out is a one-clk strobe in the cycle after each byte_tick, with sync_out/data_out/null_active valid alongside it.
interface ts_null_packet_inserter_if;
    logic        valid_in;
    logic        sync_in;
    logic [7:0]  data_in;
    logic        byte_tick;
    logic        valid_out;
    logic        sync_out;
    logic [7:0]  data_out;
    logic        null_active;
    logic [15:0] null_count;
    logic [15:0] drop_count;
    logic [1:0]  w_state_dbg;
    logic [1:0]  r_state_dbg;

    modport master (
        output valid_in, sync_in, data_in, byte_tick,
        input  valid_out, sync_out, data_out, null_active, null_count, drop_count, w_state_dbg, r_state_dbg
    );
    modport slave (
        input  valid_in, sync_in, data_in, byte_tick,
        output valid_out, sync_out, data_out, null_active, null_count, drop_count, w_state_dbg, r_state_dbg
    );
endinterface

// File: rtl/ts_null_packet_inserter.sv
// Buffers complete TS packets and plays out one byte per tick, filling gaps with null packets.
module ts_null_packet_inserter #(
    parameter int          ADDR_WIDTH = 9,
    parameter int          PKT_LEN    = 188,
    parameter logic [12:0] NULL_PID   = 13'h1FFF
) (
    input logic                      clk,
    input logic                      rst,
    ts_null_packet_inserter_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int IW    = $clog2(PKT_LEN + 1);
    localparam logic [ADDR_WIDTH+1:0] DEPTH_W  = (ADDR_WIDTH+2)'(DEPTH);
    localparam logic [ADDR_WIDTH+1:0] PKT_W    = (ADDR_WIDTH+2)'(PKT_LEN);
    localparam logic [IW-1:0]         LAST_CNT = IW'(PKT_LEN);
    localparam logic [IW-1:0]         LAST_IDX = IW'(PKT_LEN - 1);

    typedef enum logic [1:0] {HUNT, FILL} w_state_t;
    typedef enum logic [1:0] {PKT_START, SEND_REAL, SEND_NULL} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr, wr_next, wr_base, rd_ptr, rd_next, pkt_start, start_next, used, pkt_ready;
    logic [ADDR_WIDTH+1:0] free_space;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [IW-1:0]         wcnt, wcnt_next, byte_idx, idx_next;
    logic                  we, pkt_done, pkt_done_q, pkt_dec, null_inc, null_next;
    logic [1:0]            drop_inc;
    logic [16:0]           drop_sum;
    logic [7:0]            byte_val, data_q;
    logic                  valid_q, sync_q, null_q;
    logic [15:0]           null_cnt_q, drop_cnt_q;

    // A sync seen mid-fill rewinds to the packet start first, then competes for space like any fresh sync.
    always_comb begin
        w_next     = w_state;
        wr_next    = wr_ptr;
        start_next = pkt_start;
        wcnt_next  = wcnt;
        wr_base    = wr_ptr;
        waddr      = wr_ptr[ADDR_WIDTH-1:0];
        we         = 1'b0;
        pkt_done   = 1'b0;
        drop_inc   = 2'd0;
        if (bus.valid_in && bus.sync_in && w_state == FILL) begin
            wr_base  = pkt_start;
            drop_inc = 2'd1;
        end
        used       = wr_base - rd_ptr;
        free_space = DEPTH_W - {1'b0, used};
        if (bus.valid_in) begin
            if (bus.sync_in) begin
                if (free_space >= PKT_W) begin
                    we         = 1'b1;
                    waddr      = wr_base[ADDR_WIDTH-1:0];
                    start_next = wr_base;
                    wr_next    = wr_base + 1'b1;
                    wcnt_next  = IW'(1);
                    w_next     = FILL;
                end else begin
                    drop_inc = drop_inc + 2'd1;
                    wr_next  = wr_base;
                    w_next   = HUNT;
                end
            end else if (w_state == FILL) begin
                we        = 1'b1;
                wr_next   = wr_ptr + 1'b1;
                wcnt_next = wcnt + 1'b1;
                if (wcnt + 1'b1 == LAST_CNT) begin
                    pkt_done = 1'b1;
                    w_next   = HUNT;
                end
            end
        end
    end

    always_comb begin
        r_next    = r_state;
        rd_next   = rd_ptr;
        idx_next  = byte_idx;
        byte_val  = data_q;
        null_next = null_q;
        null_inc  = 1'b0;
        pkt_dec   = 1'b0;
        if (bus.byte_tick) begin
            idx_next = (byte_idx == LAST_IDX) ? '0 : byte_idx + 1'b1;
            unique case (r_state)
                PKT_START: begin
                    if (pkt_ready != '0) begin
                        byte_val  = mem[rd_ptr[ADDR_WIDTH-1:0]];
                        rd_next   = rd_ptr + 1'b1;
                        null_next = 1'b0;
                        r_next    = SEND_REAL;
                    end else begin
                        byte_val  = 8'h47;
                        null_inc  = 1'b1;
                        null_next = 1'b1;
                        r_next    = SEND_NULL;
                    end
                end
                SEND_REAL: begin
                    byte_val = mem[rd_ptr[ADDR_WIDTH-1:0]];
                    rd_next  = rd_ptr + 1'b1;
                    if (byte_idx == LAST_IDX) begin
                        pkt_dec = 1'b1;
                        r_next  = PKT_START;
                    end
                end
                SEND_NULL: begin
                    if (byte_idx == IW'(1))      byte_val = {3'b000, NULL_PID[12:8]};
                    else if (byte_idx == IW'(2)) byte_val = NULL_PID[7:0];
                    else if (byte_idx == IW'(3)) byte_val = 8'h10;
                    else                         byte_val = 8'hFF;
                    if (byte_idx == LAST_IDX) r_next = PKT_START;
                end
                default: r_next = PKT_START;
            endcase
        end
    end

    assign drop_sum = {1'b0, drop_cnt_q} + 17'(drop_inc);

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= bus.data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state    <= HUNT;
            r_state    <= PKT_START;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pkt_start  <= '0;
            wcnt       <= '0;
            byte_idx   <= '0;
            pkt_ready  <= '0;
            pkt_done_q <= 1'b0;
            valid_q    <= 1'b0;
            sync_q     <= 1'b0;
            data_q     <= 8'h00;
            null_q     <= 1'b0;
            null_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            w_state    <= w_next;
            r_state    <= r_next;
            wr_ptr     <= wr_next;
            rd_ptr     <= rd_next;
            pkt_start  <= start_next;
            wcnt       <= wcnt_next;
            byte_idx   <= idx_next;
            pkt_done_q <= pkt_done;
            valid_q    <= bus.byte_tick;
            sync_q     <= bus.byte_tick && (byte_idx == '0);
            data_q     <= byte_val;
            null_q     <= null_next;
            // A packet completed this cycle becomes readable one cycle later.
            if (pkt_done_q && !pkt_dec)      pkt_ready <= pkt_ready + 1'b1;
            else if (!pkt_done_q && pkt_dec) pkt_ready <= pkt_ready - 1'b1;
            if (null_inc && null_cnt_q != 16'hFFFF) null_cnt_q <= null_cnt_q + 1'b1;
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign bus.valid_out   = valid_q;
    assign bus.sync_out    = sync_q;
    assign bus.data_out    = data_q;
    assign bus.null_active = null_q;
    assign bus.null_count  = null_cnt_q;
    assign bus.drop_count  = drop_cnt_q;
    assign bus.w_state_dbg = w_state;
    assign bus.r_state_dbg = r_state;
endmodule

// File: tb/tb_ts_null_packet_inserter.sv
// Bench for ts_null_packet_inserter: reset vectors, directed packet scenarios and random phases against a packet-level model.
module tb_ts_null_packet_inserter;
    localparam int PKT_LEN = 188;
    localparam int DEPTH   = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ts_null_packet_inserter_if bus();

    ts_null_packet_inserter #(
        .ADDR_WIDTH(9),
        .PKT_LEN   (PKT_LEN),
        .NULL_PID  (13'h1FFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        valid;
        logic        sync;
        logic [7:0]  data;
        logic        tick;
        logic [10:0] exp;   // {valid_out, sync_out, null_active, data_out}
    } vec_t;

    vec_t        vecs[10];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [9:0]  exp_q[$];  // {sync_out, null_active, data_out}
    logic [9:0]  act_q[$];
    logic [7:0]  mdl_buf[$];
    logic [7:0]  wpkt[PKT_LEN];
    int          mdl_null = 0;
    int          mdl_drop = 0;
    bit          mon_en   = 1'b0;

    always @(negedge clk) begin
        if (mon_en && bus.valid_out) act_q.push_back({bus.sync_out, bus.null_active, bus.data_out});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.valid_in = 1'b0;
        bus.byte_tick = 1'b0;
        idle(2);
        rst = 1'b0;
        mdl_buf.delete();
        exp_q.delete();
        act_q.delete();
        mdl_null = 0;
        mdl_drop = 0;
    endtask

    task automatic make_pkt();
        wpkt[0] = 8'h47;
        for (int i = 1; i < PKT_LEN; i++) wpkt[i] = 8'($urandom);
    endtask

    task automatic drive_byte(input logic s, input logic [7:0] d);
        bus.valid_in = 1'b1;
        bus.sync_in  = s;
        bus.data_in  = d;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        bus.sync_in  = 1'($urandom);
        bus.data_in  = 8'($urandom);
    endtask

    task automatic send_packet(input int len, input int max_gap);
        for (int i = 0; i < len; i++) begin
            drive_byte(i == 0, wpkt[i]);
            idle($urandom_range(max_gap, 0));
        end
        idle(3);
    endtask

    task automatic send_ticks(input int n, input int min_gap, input int max_gap);
        for (int i = 0; i < n; i++) begin
            bus.byte_tick = 1'b1;
            @(posedge clk);
            #1;
            bus.byte_tick = 1'b0;
            idle($urandom_range(max_gap, min_gap));
        end
    endtask

    function automatic logic [7:0] null_byte(input int i);
        logic [12:0] pid;
        pid = 13'h1FFF;
        if (i == 0) return 8'h47;
        if (i == 1) return {3'b000, pid[12:8]};
        if (i == 2) return pid[7:0];
        if (i == 3) return 8'h10;
        return 8'hFF;
    endfunction

    // Packet accepted only if a whole packet still fits beside what is buffered.
    task automatic mdl_write_full();
        if (mdl_buf.size() + PKT_LEN <= DEPTH) begin
            for (int i = 0; i < PKT_LEN; i++) mdl_buf.push_back(wpkt[i]);
        end else begin
            mdl_drop++;
        end
    endtask

    task automatic mdl_out_packet();
        if (mdl_buf.size() >= PKT_LEN) begin
            for (int i = 0; i < PKT_LEN; i++) exp_q.push_back({1'(i == 0), 1'b0, mdl_buf.pop_front()});
        end else begin
            mdl_null++;
            for (int i = 0; i < PKT_LEN; i++) exp_q.push_back({1'(i == 0), 1'b1, null_byte(i)});
        end
    endtask

    task automatic check_stream(input string name);
        int         bad;
        logic [9:0] a, e, ba, be;
        idle(3);
        check({name, " byte count"}, act_q.size(), exp_q.size());
        while (exp_q.size() >= PKT_LEN && act_q.size() >= PKT_LEN) begin
            bad = -1;
            ba  = '0;
            be  = '0;
            for (int i = 0; i < PKT_LEN; i++) begin
                a = act_q.pop_front();
                e = exp_q.pop_front();
                if (bad < 0 && a !== e) begin
                    bad = i;
                    ba  = a;
                    be  = e;
                end
            end
            n_checks++;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL %s packet byte %0d: got %h expected %h", name, bad, ba, be);
            end
        end
        act_q.delete();
        exp_q.delete();
        check({name, " null_count"}, bus.null_count, mdl_null);
        check({name, " drop_count"}, bus.drop_count, mdl_drop);
    endtask

    initial begin
        int kind;
        bus.valid_in  = 1'b0;
        bus.sync_in   = 1'b0;
        bus.data_in   = 8'h00;
        bus.byte_tick = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b0, {3'b000, 8'h00}};
        vecs[1] = '{1'b1, 1'b0, 8'h47, 1'b0, {3'b000, 8'h00}};
        vecs[2] = '{1'b0, 1'b1, 8'h47, 1'b1, {3'b111, 8'h47}};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b0, {3'b001, 8'h47}};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b1, {3'b101, 8'h1F}};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, {3'b101, 8'hFF}};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b0, {3'b001, 8'hFF}};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, {3'b101, 8'h10}};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b1, {3'b101, 8'hFF}};
        vecs[9] = '{1'b0, 1'b0, 8'h00, 1'b0, {3'b001, 8'hFF}};

        do_reset();
        check("reset outputs", {bus.valid_out, bus.sync_out, bus.null_active, bus.data_out}, 0);
        check("reset counters", {bus.null_count, bus.drop_count}, 0);
        for (int i = 0; i < 10; i++) begin
            bus.valid_in  = vecs[i].valid;
            bus.sync_in   = vecs[i].sync;
            bus.data_in   = vecs[i].data;
            bus.byte_tick = vecs[i].tick;
            @(posedge clk);
            #1;
            check($sformatf("vector %0d", i), {bus.valid_out, bus.sync_out, bus.null_active, bus.data_out}, vecs[i].exp);
        end
        bus.valid_in  = 1'b0;
        bus.byte_tick = 1'b0;
        check("vector null_count", bus.null_count, 1);

        mon_en = 1'b1;
        do_reset();
        mdl_out_packet();
        mdl_out_packet();
        send_ticks(2 * PKT_LEN, 0, 0);
        check_stream("two nulls");

        do_reset();
        make_pkt();
        mdl_write_full();
        send_packet(PKT_LEN, 1);
        mdl_out_packet();
        send_ticks(PKT_LEN, 0, 1);
        check_stream("one real");

        do_reset();
        make_pkt();
        mdl_out_packet();
        mdl_write_full();
        mdl_out_packet();
        fork
            send_ticks(2 * PKT_LEN, 1, 2);
            begin
                idle(5);
                send_packet(PKT_LEN, 0);
            end
        join
        check_stream("mid-null arrival");

        do_reset();
        make_pkt();
        send_packet(100, 0);
        mdl_drop++;
        make_pkt();
        mdl_write_full();
        send_packet(PKT_LEN, 0);
        mdl_out_packet();
        send_ticks(PKT_LEN, 0, 0);
        check_stream("truncated");

        do_reset();
        repeat (4) begin
            make_pkt();
            mdl_write_full();
            send_packet(PKT_LEN, 0);
        end
        repeat (3) mdl_out_packet();
        send_ticks(3 * PKT_LEN, 0, 0);
        check_stream("burst of four");

        mon_en = 1'b0;
        make_pkt();
        send_packet(PKT_LEN, 0);
        send_ticks(50, 0, 0);
        rst = 1'b1;
        bus.byte_tick = 1'b1;
        @(posedge clk);
        #1;
        check("reset mid-packet outputs", {bus.valid_out, bus.sync_out, bus.null_active, bus.data_out}, 0);
        check("reset mid-packet counters", {bus.null_count, bus.drop_count}, 0);
        rst = 1'b0;
        bus.byte_tick = 1'b0;
        idle(1);
        bus.byte_tick = 1'b1;
        @(posedge clk);
        #1;
        bus.byte_tick = 1'b0;
        check("first byte after reset", {bus.valid_out, bus.sync_out, bus.null_active, bus.data_out}, {3'b111, 8'h47});
        check("null_count after reset", bus.null_count, 1);

        mon_en = 1'b1;
        do_reset();
        repeat (25) begin
            kind = $urandom_range(9, 0);
            if (kind <= 3) begin
                make_pkt();
                mdl_write_full();
                send_packet(PKT_LEN, 2);
            end else if (kind == 4) begin
                make_pkt();
                send_packet($urandom_range(PKT_LEN - 1, 1), 1);
                mdl_drop++;
                make_pkt();
                mdl_write_full();
                send_packet(PKT_LEN, 1);
            end else begin
                mdl_out_packet();
                send_ticks(PKT_LEN, 0, 2);
            end
        end
        check_stream("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
